// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN for write-through forwarding to the read ports.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic                  en;
        logic [DATA_WIDTH-1:0] q;
        // Enable gated first so an unknown index with writes disabled cannot fire.
        assign en = ctrl_writeEnable && (ctrl_writeReg == ADDR_WIDTH'(i));
        always_ff @(posedge clk or posedge rst)
            if (rst) q <= '0;
            else if (en) q <= data_writeReg;
        assign regs[i] = q;
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live, hit_a, hit_b;
    assign wr_live = !rst && ctrl_writeEnable && (ctrl_writeReg != '0);
    assign hit_a   = wr_live && (ctrl_writeReg == ctrl_readRegA);
    assign hit_b   = wr_live && (ctrl_writeReg == ctrl_readRegB);
    assign data_readRegA = hit_a ? data_writeReg : regs[ctrl_readRegA];
    assign data_readRegB = hit_b ? data_writeReg : regs[ctrl_readRegB];
`else
    assign data_readRegA = regs[ctrl_readRegA];
    assign data_readRegB = regs[ctrl_readRegB];
`endif
endmodule
